// File: rtl/inv_sub_byte_iter.sv
// ---------------------------------------------------------------------------
// inv_sub_byte_iter
//
// Iterative AES inverse SubBytes engine for the decrypt round datapath. It
// sits between inverse ShiftRows and AddRoundKey. A 128-bit state is
// accepted on an in_valid/in_ready handshake. The state is then rewritten
// BYTES_PER_CYCLE bytes per clock through a shared bank of inverse S-boxes.
// The finished state is presented on an out_valid/out_ready handshake.
//
// Byte i of a state occupies bits [8i:8i+7], so byte 0 is the most
// significant byte. Bytes are processed in ascending index order.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_key carries a state to be transformed
//   in_ready   engine is idle and will take in_key on this edge
//   in_key     input state [0:127]
//   out_valid  out_key holds a completed result
//   out_ready  downstream takes out_key on this edge
//   out_key    inverse-substituted state [0:127]; holds the last result
//   busy       substitution in progress
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// inv_sbox: FIPS-197 inverse S-box as a purely combinational 256-entry ROM.
//   byte_i  substituted byte
//   byte_o  InvSbox(byte_i)
// ---------------------------------------------------------------------------
module inv_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // that no path can leave it unassigned and infer a latch.
        byte_o = 8'h00;
        case (byte_i)
            8'h00: byte_o = 8'h52; 8'h01: byte_o = 8'h09; 8'h02: byte_o = 8'h6a; 8'h03: byte_o = 8'hd5;
            8'h04: byte_o = 8'h30; 8'h05: byte_o = 8'h36; 8'h06: byte_o = 8'ha5; 8'h07: byte_o = 8'h38;
            8'h08: byte_o = 8'hbf; 8'h09: byte_o = 8'h40; 8'h0a: byte_o = 8'ha3; 8'h0b: byte_o = 8'h9e;
            8'h0c: byte_o = 8'h81; 8'h0d: byte_o = 8'hf3; 8'h0e: byte_o = 8'hd7; 8'h0f: byte_o = 8'hfb;
            8'h10: byte_o = 8'h7c; 8'h11: byte_o = 8'he3; 8'h12: byte_o = 8'h39; 8'h13: byte_o = 8'h82;
            8'h14: byte_o = 8'h9b; 8'h15: byte_o = 8'h2f; 8'h16: byte_o = 8'hff; 8'h17: byte_o = 8'h87;
            8'h18: byte_o = 8'h34; 8'h19: byte_o = 8'h8e; 8'h1a: byte_o = 8'h43; 8'h1b: byte_o = 8'h44;
            8'h1c: byte_o = 8'hc4; 8'h1d: byte_o = 8'hde; 8'h1e: byte_o = 8'he9; 8'h1f: byte_o = 8'hcb;
            8'h20: byte_o = 8'h54; 8'h21: byte_o = 8'h7b; 8'h22: byte_o = 8'h94; 8'h23: byte_o = 8'h32;
            8'h24: byte_o = 8'ha6; 8'h25: byte_o = 8'hc2; 8'h26: byte_o = 8'h23; 8'h27: byte_o = 8'h3d;
            8'h28: byte_o = 8'hee; 8'h29: byte_o = 8'h4c; 8'h2a: byte_o = 8'h95; 8'h2b: byte_o = 8'h0b;
            8'h2c: byte_o = 8'h42; 8'h2d: byte_o = 8'hfa; 8'h2e: byte_o = 8'hc3; 8'h2f: byte_o = 8'h4e;
            8'h30: byte_o = 8'h08; 8'h31: byte_o = 8'h2e; 8'h32: byte_o = 8'ha1; 8'h33: byte_o = 8'h66;
            8'h34: byte_o = 8'h28; 8'h35: byte_o = 8'hd9; 8'h36: byte_o = 8'h24; 8'h37: byte_o = 8'hb2;
            8'h38: byte_o = 8'h76; 8'h39: byte_o = 8'h5b; 8'h3a: byte_o = 8'ha2; 8'h3b: byte_o = 8'h49;
            8'h3c: byte_o = 8'h6d; 8'h3d: byte_o = 8'h8b; 8'h3e: byte_o = 8'hd1; 8'h3f: byte_o = 8'h25;
            8'h40: byte_o = 8'h72; 8'h41: byte_o = 8'hf8; 8'h42: byte_o = 8'hf6; 8'h43: byte_o = 8'h64;
            8'h44: byte_o = 8'h86; 8'h45: byte_o = 8'h68; 8'h46: byte_o = 8'h98; 8'h47: byte_o = 8'h16;
            8'h48: byte_o = 8'hd4; 8'h49: byte_o = 8'ha4; 8'h4a: byte_o = 8'h5c; 8'h4b: byte_o = 8'hcc;
            8'h4c: byte_o = 8'h5d; 8'h4d: byte_o = 8'h65; 8'h4e: byte_o = 8'hb6; 8'h4f: byte_o = 8'h92;
            8'h50: byte_o = 8'h6c; 8'h51: byte_o = 8'h70; 8'h52: byte_o = 8'h48; 8'h53: byte_o = 8'h50;
            8'h54: byte_o = 8'hfd; 8'h55: byte_o = 8'hed; 8'h56: byte_o = 8'hb9; 8'h57: byte_o = 8'hda;
            8'h58: byte_o = 8'h5e; 8'h59: byte_o = 8'h15; 8'h5a: byte_o = 8'h46; 8'h5b: byte_o = 8'h57;
            8'h5c: byte_o = 8'ha7; 8'h5d: byte_o = 8'h8d; 8'h5e: byte_o = 8'h9d; 8'h5f: byte_o = 8'h84;
            8'h60: byte_o = 8'h90; 8'h61: byte_o = 8'hd8; 8'h62: byte_o = 8'hab; 8'h63: byte_o = 8'h00;
            8'h64: byte_o = 8'h8c; 8'h65: byte_o = 8'hbc; 8'h66: byte_o = 8'hd3; 8'h67: byte_o = 8'h0a;
            8'h68: byte_o = 8'hf7; 8'h69: byte_o = 8'he4; 8'h6a: byte_o = 8'h58; 8'h6b: byte_o = 8'h05;
            8'h6c: byte_o = 8'hb8; 8'h6d: byte_o = 8'hb3; 8'h6e: byte_o = 8'h45; 8'h6f: byte_o = 8'h06;
            8'h70: byte_o = 8'hd0; 8'h71: byte_o = 8'h2c; 8'h72: byte_o = 8'h1e; 8'h73: byte_o = 8'h8f;
            8'h74: byte_o = 8'hca; 8'h75: byte_o = 8'h3f; 8'h76: byte_o = 8'h0f; 8'h77: byte_o = 8'h02;
            8'h78: byte_o = 8'hc1; 8'h79: byte_o = 8'haf; 8'h7a: byte_o = 8'hbd; 8'h7b: byte_o = 8'h03;
            8'h7c: byte_o = 8'h01; 8'h7d: byte_o = 8'h13; 8'h7e: byte_o = 8'h8a; 8'h7f: byte_o = 8'h6b;
            8'h80: byte_o = 8'h3a; 8'h81: byte_o = 8'h91; 8'h82: byte_o = 8'h11; 8'h83: byte_o = 8'h41;
            8'h84: byte_o = 8'h4f; 8'h85: byte_o = 8'h67; 8'h86: byte_o = 8'hdc; 8'h87: byte_o = 8'hea;
            8'h88: byte_o = 8'h97; 8'h89: byte_o = 8'hf2; 8'h8a: byte_o = 8'hcf; 8'h8b: byte_o = 8'hce;
            8'h8c: byte_o = 8'hf0; 8'h8d: byte_o = 8'hb4; 8'h8e: byte_o = 8'he6; 8'h8f: byte_o = 8'h73;
            8'h90: byte_o = 8'h96; 8'h91: byte_o = 8'hac; 8'h92: byte_o = 8'h74; 8'h93: byte_o = 8'h22;
            8'h94: byte_o = 8'he7; 8'h95: byte_o = 8'had; 8'h96: byte_o = 8'h35; 8'h97: byte_o = 8'h85;
            8'h98: byte_o = 8'he2; 8'h99: byte_o = 8'hf9; 8'h9a: byte_o = 8'h37; 8'h9b: byte_o = 8'he8;
            8'h9c: byte_o = 8'h1c; 8'h9d: byte_o = 8'h75; 8'h9e: byte_o = 8'hdf; 8'h9f: byte_o = 8'h6e;
            8'ha0: byte_o = 8'h47; 8'ha1: byte_o = 8'hf1; 8'ha2: byte_o = 8'h1a; 8'ha3: byte_o = 8'h71;
            8'ha4: byte_o = 8'h1d; 8'ha5: byte_o = 8'h29; 8'ha6: byte_o = 8'hc5; 8'ha7: byte_o = 8'h89;
            8'ha8: byte_o = 8'h6f; 8'ha9: byte_o = 8'hb7; 8'haa: byte_o = 8'h62; 8'hab: byte_o = 8'h0e;
            8'hac: byte_o = 8'haa; 8'had: byte_o = 8'h18; 8'hae: byte_o = 8'hbe; 8'haf: byte_o = 8'h1b;
            8'hb0: byte_o = 8'hfc; 8'hb1: byte_o = 8'h56; 8'hb2: byte_o = 8'h3e; 8'hb3: byte_o = 8'h4b;
            8'hb4: byte_o = 8'hc6; 8'hb5: byte_o = 8'hd2; 8'hb6: byte_o = 8'h79; 8'hb7: byte_o = 8'h20;
            8'hb8: byte_o = 8'h9a; 8'hb9: byte_o = 8'hdb; 8'hba: byte_o = 8'hc0; 8'hbb: byte_o = 8'hfe;
            8'hbc: byte_o = 8'h78; 8'hbd: byte_o = 8'hcd; 8'hbe: byte_o = 8'h5a; 8'hbf: byte_o = 8'hf4;
            8'hc0: byte_o = 8'h1f; 8'hc1: byte_o = 8'hdd; 8'hc2: byte_o = 8'ha8; 8'hc3: byte_o = 8'h33;
            8'hc4: byte_o = 8'h88; 8'hc5: byte_o = 8'h07; 8'hc6: byte_o = 8'hc7; 8'hc7: byte_o = 8'h31;
            8'hc8: byte_o = 8'hb1; 8'hc9: byte_o = 8'h12; 8'hca: byte_o = 8'h10; 8'hcb: byte_o = 8'h59;
            8'hcc: byte_o = 8'h27; 8'hcd: byte_o = 8'h80; 8'hce: byte_o = 8'hec; 8'hcf: byte_o = 8'h5f;
            8'hd0: byte_o = 8'h60; 8'hd1: byte_o = 8'h51; 8'hd2: byte_o = 8'h7f; 8'hd3: byte_o = 8'ha9;
            8'hd4: byte_o = 8'h19; 8'hd5: byte_o = 8'hb5; 8'hd6: byte_o = 8'h4a; 8'hd7: byte_o = 8'h0d;
            8'hd8: byte_o = 8'h2d; 8'hd9: byte_o = 8'he5; 8'hda: byte_o = 8'h7a; 8'hdb: byte_o = 8'h9f;
            8'hdc: byte_o = 8'h93; 8'hdd: byte_o = 8'hc9; 8'hde: byte_o = 8'h9c; 8'hdf: byte_o = 8'hef;
            8'he0: byte_o = 8'ha0; 8'he1: byte_o = 8'he0; 8'he2: byte_o = 8'h3b; 8'he3: byte_o = 8'h4d;
            8'he4: byte_o = 8'hae; 8'he5: byte_o = 8'h2a; 8'he6: byte_o = 8'hf5; 8'he7: byte_o = 8'hb0;
            8'he8: byte_o = 8'hc8; 8'he9: byte_o = 8'heb; 8'hea: byte_o = 8'hbb; 8'heb: byte_o = 8'h3c;
            8'hec: byte_o = 8'h83; 8'hed: byte_o = 8'h53; 8'hee: byte_o = 8'h99; 8'hef: byte_o = 8'h61;
            8'hf0: byte_o = 8'h17; 8'hf1: byte_o = 8'h2b; 8'hf2: byte_o = 8'h04; 8'hf3: byte_o = 8'h7e;
            8'hf4: byte_o = 8'hba; 8'hf5: byte_o = 8'h77; 8'hf6: byte_o = 8'hd6; 8'hf7: byte_o = 8'h26;
            8'hf8: byte_o = 8'he1; 8'hf9: byte_o = 8'h69; 8'hfa: byte_o = 8'h14; 8'hfb: byte_o = 8'h63;
            8'hfc: byte_o = 8'h55; 8'hfd: byte_o = 8'h21; 8'hfe: byte_o = 8'h0c; 8'hff: byte_o = 8'h7d;
            default: byte_o = 8'h00;
        endcase
    end

endmodule

module inv_sub_byte_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_key,
    output logic         busy
);

    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int CHUNK_W   = 8 * BYTES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    // Only divisors of 16 that are powers of two give whole, aligned chunks.
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bytes_per_cycle
        $error("inv_sub_byte_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [0:127]       data_q, data_d;
    logic [0:127]       out_key_q, out_key_d;
    logic               in_ready_q, in_ready_d;

    logic [6:0]         base_bit;
    logic [0:CHUNK_W-1] chunk_in;
    logic [0:CHUNK_W-1] chunk_out;
    logic               accept;
    logic               last_step;

    // Bit offset of the chunk handled this step. With a single step the
    // whole state is one chunk and the counter plays no part.
    assign base_bit  = (NUM_STEPS == 1) ? 7'd0 : 7'(cnt_q) * 7'(CHUNK_W);
    assign chunk_in  = data_q[base_bit +: CHUNK_W];
    assign last_step = (cnt_q == LAST_STEP);

    // in_ready_q is only ever set while idle, so it alone qualifies the accept.
    assign accept = in_valid && in_ready_q;

    // Shared S-box bank, time-multiplexed over the state by the step counter.
    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .byte_i (chunk_in[8*j +: 8]),
            .byte_o (chunk_out[8*j +: 8])
        );
    end

    // State register process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            // NOTE: the wide data and result registers are reset on purpose.
            // An aborted block must leave no residue, and out_key must read
            // zero from reset onwards.
            data_q     <= '0;
            out_key_q  <= '0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            out_key_q  <= out_key_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state and datapath process.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        out_key_d = out_key_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = in_key;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                data_d[base_bit +: CHUNK_W] = chunk_out;
                if (last_step) begin
                    cnt_d     = '0;
                    out_key_d = data_d;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered ready follows the next state. It is therefore low while
        // in reset, and it rises in the cycle after the DONE->IDLE edge.
        in_ready_d = (state_d == S_IDLE);
    end

    // Output process.
    always_comb begin
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_BUSY);
    end

    assign in_ready = in_ready_q;
    assign out_key  = out_key_q;

endmodule

// File: doc/inv_sub_byte_iter.md
Name: inv_sub_byte_iter

Overview:
- Iterative inverse SubBytes engine for the AES-128 decryption datapath.
- It is the inverse of the combinational forward byte-substitution stage and applies the FIPS-197 inverse S-box to each of the 16 state bytes.
- It processes BYTES_PER_CYCLE bytes per clock over a shared, time-multiplexed inverse S-box bank.
- It sits between the decrypt round's inverse ShiftRows and AddRoundKey stages, with valid/ready handshakes on both sides.

Parameters:
- BYTES_PER_CYCLE, 4, number of inverse S-box lookups per clock. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- NUM_STEPS, 16/BYTES_PER_CYCLE, derived (localparam), number of BUSY cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_key is valid
- in_ready  output  1  block can accept a new state
- in_key  input  [0:127]  input state; byte i = bits [8i:8i+7]; byte 0 is the MSB byte
- out_valid  output  1  out_key holds a completed result
- out_ready  input  1  downstream accepts out_key
- out_key  output  [0:127]  inverse-substituted state, same byte ordering
- busy  output  1  high in BUSY state

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, step counter=0, internal state register=0.
  - out_key=0, out_valid=0, busy=0.
  - in_ready=1 from the first cycle after reset deasserts. in_ready is 0 while rst_n is low.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On rising edge with in_valid&&in_ready: capture in_key into the state register, counter=0, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each edge replaces bytes [counter*BYTES_PER_CYCLE .. counter*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1] with InvSbox(byte) and increments the counter. Bytes are processed in ascending index order. On the edge where counter==NUM_STEPS-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. out_key equals the state register and is held stable until the handshake. On edge with out_valid&&out_ready, go to IDLE and clear out_valid.
- Latency:
  - out_valid rises exactly NUM_STEPS rising edges after the accepting edge (4 for the default).
  - Throughput is one block per NUM_STEPS+2 cycles when out_ready is held high.
- out_key while not in DONE holds the last completed result (0 after reset). Downstream may only sample it when out_valid=1.
- No input/output overlap: in_ready never goes high in the same cycle as a DONE->IDLE transition. The next accept occurs at the earliest one cycle after out_valid falls.
- in_valid while not in IDLE is ignored. in_key is not sampled again.
- out_ready outside DONE has no effect.
- Back-pressure: out_ready low in DONE holds DONE indefinitely with out_key unchanged.
- Reset mid-BUSY or mid-DONE aborts the block; all outputs return to reset values immediately.
- Inverse S-box: full 256-entry FIPS-197 inverse table, purely combinational, BYTES_PER_CYCLE instances. Byte values are unsigned 8-bit; no width extension.
- BYTES_PER_CYCLE=16: single BUSY cycle, NUM_STEPS=1, the counter is unused but legal.

Test Plan:
- Reset, then assert in_valid with in_key=0x637c777bf26b6fc53001672bfed7ab76 -> out_valid rises 4 edges after accept; out_key=0x000102030405060708090a0b0c0d0e0f.
- in_key=all bytes 0x63 -> out_key=all 0x00. in_key=all 0x16 -> out_key=all 0xFF. in_key with byte 5=0xED, all other bytes 0x63 -> byte 5 is 0x53, all other bytes 0x00.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid with a new in_key -> out_key is unchanged, in_ready stays 0, no second accept. Release out_ready -> out_valid falls, then in_ready=1 the next cycle.
- Pulse rst_n low during BUSY (second step) -> out_valid=0, busy=0, out_key=0 immediately. A new block after reset completes correctly with no residue from the aborted block.
- Back-to-back blocks with out_ready tied high -> 100 random states each match a reference model. Spacing is NUM_STEPS+2 cycles, and in_ready is never high while busy=1 or out_valid=1.
- Parameter sweep BYTES_PER_CYCLE in {1,2,8,16} -> latency is 16, 8, 2 and 1 edges respectively, with identical results for the first vector. BYTES_PER_CYCLE=3 fails elaboration.
